mux41_scan_seq: RTL and testbench

- Upstream sequencer for the 4:1 enabled mux stage.
- Accepts a 4-bit word over a valid/ready handshake and registers it onto the mux data lines.
- Steps the 2-bit channel select through all four inputs, holding each for a programmable number of clocks with enable high, so the mux emits the word serially.
- Signals completion with a one-cycle done pulse, then observes an optional inter-word gap before accepting the next word.

---
 rtl/mux41_scan_seq.sv | 161 ++++++++++++++++
 tb/tb_mux41_scan_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux41_scan_seq.sv
// mux41_scan_seq: feeds a 4:1 enabled mux. Latches a 4-bit word on a valid/ready
// handshake, then walks the channel select across all four inputs with enable high,
// holding each channel for DIV clocks, pulses done, and idles GAP_CYCLES clocks.
// Optional build macro SCAN_MSB_FIRST_EN: scan channels 3,2,1,0 instead of 0,1,2,3.

module mux41_scan_seq #(
    parameter int unsigned DIV        = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic [3:0] d,
    output logic [1:0] select,
    output logic       en,
    output logic       busy,
    output logic       done
);

    // Counter widths: div_cnt must hold DIV-1, gap_cnt must hold GAP_CYCLES.
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

`ifdef SCAN_MSB_FIRST_EN
    localparam logic [1:0] SEL_FIRST = 2'd3;
    localparam logic [1:0] SEL_LAST  = 2'd0;
`else
    localparam logic [1:0] SEL_FIRST = 2'd0;
    localparam logic [1:0] SEL_LAST  = 2'd3;
`endif

    logic [1:0]       r_state;
    logic [3:0]       r_d;
    logic [1:0]       r_select;
    logic             r_en;
    logic             r_done;
    logic [DIV_W-1:0] r_div_cnt;
    logic [GAP_W-1:0] r_gap_cnt;

    logic [1:0]       w_state_nxt;
    logic [3:0]       w_d_nxt;
    logic [1:0]       w_select_nxt;
    logic             w_en_nxt;
    logic             w_done_nxt;
    logic [DIV_W-1:0] w_div_cnt_nxt;
    logic [GAP_W-1:0] w_gap_cnt_nxt;

    logic             w_div_end;
    logic             w_gap_end;
    logic             w_sel_last;
    logic [1:0]       w_select_step;

    assign w_div_end  = (r_div_cnt == DIV_W'(DIV - 1));
    // Only evaluated in the GAP state, which is unreachable when GAP_CYCLES is 0.
    assign w_gap_end  = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign w_sel_last = (r_select == SEL_LAST);

    // Step select toward the last channel in the configured scan direction.
`ifdef SCAN_MSB_FIRST_EN
    assign w_select_step = r_select - 2'd1;
`else
    assign w_select_step = r_select + 2'd1;
`endif

    // Next-state logic: abort overrides everything, including a same-edge accept or finish.
    always_comb begin
        w_state_nxt   = r_state;
        w_d_nxt       = r_d;
        w_select_nxt  = r_select;
        w_en_nxt      = r_en;
        w_done_nxt    = 1'b0;
        w_div_cnt_nxt = r_div_cnt;
        w_gap_cnt_nxt = r_gap_cnt;

        if (abort) begin
            // d and select deliberately hold so the mux lines stay quiet.
            w_state_nxt   = ST_IDLE;
            w_en_nxt      = 1'b0;
            w_div_cnt_nxt = '0;
            w_gap_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w_d_nxt       = in_data;
                        w_select_nxt  = SEL_FIRST;
                        w_en_nxt      = 1'b1;
                        w_div_cnt_nxt = '0;
                        w_state_nxt   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_div_end) begin
                        w_div_cnt_nxt = '0;
                        if (w_sel_last) begin
                            // Select stays on the last channel until the next accept.
                            w_en_nxt      = 1'b0;
                            w_done_nxt    = 1'b1;
                            w_gap_cnt_nxt = '0;
                            w_state_nxt   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                        end else begin
                            w_select_nxt = w_select_step;
                        end
                    end else begin
                        w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        w_gap_cnt_nxt = '0;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_en_nxt      = 1'b0;
                    w_div_cnt_nxt = '0;
                    w_gap_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_d       <= 4'd0;
            r_select  <= SEL_FIRST;
            r_en      <= 1'b0;
            r_done    <= 1'b0;
            r_div_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_d       <= w_d_nxt;
            r_select  <= w_select_nxt;
            r_en      <= w_en_nxt;
            r_done    <= w_done_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign d        = r_d;
    assign select   = r_select;
    assign en       = r_en;
    assign done     = r_done;

endmodule

// File: tb/tb_mux41_scan_seq.sv
// Directed bench for mux41_scan_seq: instance A (DIV=4, GAP=1), B (DIV=2, GAP=0),
// C (DIV=1, GAP=0). Outputs are sampled 1 time unit after the rising edge.

module tb_mux41_scan_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic [3:0] a_in_data, b_in_data, c_in_data;
    logic       a_in_valid, b_in_valid, c_in_valid;
    logic       a_abort, b_abort, c_abort;
    logic       a_in_ready, b_in_ready, c_in_ready;
    logic [3:0] a_d, b_d, c_d;
    logic [1:0] a_sel, b_sel, c_sel;
    logic       a_en, b_en, c_en;
    logic       a_busy, b_busy, c_busy;
    logic       a_done, b_done, c_done;

    mux41_scan_seq #(.DIV(4), .GAP_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .abort(a_abort), .d(a_d), .select(a_sel), .en(a_en),
        .busy(a_busy), .done(a_done)
    );

    mux41_scan_seq #(.DIV(2), .GAP_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .abort(b_abort), .d(b_d), .select(b_sel), .en(b_en),
        .busy(b_busy), .done(b_done)
    );

    mux41_scan_seq #(.DIV(1), .GAP_CYCLES(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .abort(c_abort), .d(c_d), .select(c_sel), .en(c_en),
        .busy(c_busy), .done(c_done)
    );

    // k-th channel in scan order for the selected build.
    function automatic logic [1:0] ch(input int k);
`ifdef SCAN_MSB_FIRST_EN
        return 2'(3 - k);
`else
        return 2'(k);
`endif
    endfunction

    function automatic logic bit_of(input logic [3:0] w, input logic [1:0] s);
        return w[s];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_data = 4'h0; a_in_valid = 1'b0; a_abort = 1'b0;
        b_in_data = 4'h0; b_in_valid = 1'b0; b_abort = 1'b0;
        c_in_data = 4'h0; c_in_valid = 1'b0; c_abort = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_en", a_en, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_d", a_d, 4'h0);
        chk("rst_select", a_sel, ch(0));
        rst_n = 1'b1;
        tick();

        // Basic word 1010 on A
        a_in_data  = 4'b1010;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        a_in_data  = 4'h0;
        chk("basic_in_ready_low", a_in_ready, 1'b0);
        chk("basic_busy", a_busy, 1'b1);
        chk("basic_d", a_d, 4'b1010);
        for (int k = 0; k < 16; k++) begin
            chk("basic_en", a_en, 1'b1);
            chk("basic_select", a_sel, ch(k / 4));
            chk("basic_mux_out", bit_of(a_d, a_sel), bit_of(4'b1010, ch(k / 4)));
            chk("basic_no_done", a_done, 1'b0);
            tick();
        end
        chk("basic_en_fall", a_en, 1'b0);
        chk("basic_done", a_done, 1'b1);
        chk("basic_gap_busy", a_busy, 1'b1);
        chk("basic_gap_ready", a_in_ready, 1'b0);
        tick();
        chk("basic_done_pulse", a_done, 1'b0);
        chk("basic_ready_back", a_in_ready, 1'b1);
        chk("basic_d_hold", a_d, 4'b1010);
        chk("basic_sel_hold", a_sel, ch(3));

        // Asynchronous reset mid-SHIFT
        a_in_data  = 4'h5;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("mid_en_before_rst", a_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_en", a_en, 1'b0);
        chk("arst_done", a_done, 1'b0);
        chk("arst_d", a_d, 4'h0);
        chk("arst_select", a_sel, ch(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_ready_after", a_in_ready, 1'b1);
        chk("arst_busy_after", a_busy, 1'b0);

        // Abort on the 6th cycle of a word
        a_in_data  = 4'hC;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("abort_pre_en", a_en, 1'b1);
        chk("abort_pre_sel", a_sel, ch(1));
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        chk("abort_en", a_en, 1'b0);
        chk("abort_busy", a_busy, 1'b0);
        chk("abort_ready", a_in_ready, 1'b1);
        chk("abort_no_done", a_done, 1'b0);
        chk("abort_d_hold", a_d, 4'hC);
        chk("abort_sel_hold", a_sel, ch(1));
        tick();
        chk("abort_no_done_later", a_done, 1'b0);

        // abort and in_valid together in IDLE
        a_in_data  = 4'h3;
        a_in_valid = 1'b1;
        a_abort    = 1'b1;
        tick();
        a_in_valid = 1'b0;
        a_abort    = 1'b0;
        chk("simul_busy", a_busy, 1'b0);
        chk("simul_en", a_en, 1'b0);
        chk("simul_d", a_d, 4'hC);

        // abort on the final SHIFT cycle
        a_in_data  = 4'h6;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("final_pre_en", a_en, 1'b1);
        chk("final_pre_sel", a_sel, ch(3));
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        chk("final_abort_done", a_done, 1'b0);
        chk("final_abort_en", a_en, 1'b0);
        chk("final_abort_busy", a_busy, 1'b0);

        // Back-to-back on B: valid held, F then 3
        b_in_data  = 4'hF;
        b_in_valid = 1'b1;
        tick();
        b_in_data = 4'h3;
        for (int k = 0; k < 8; k++) begin
            chk("b2b_w1_en", b_en, 1'b1);
            chk("b2b_w1_d", b_d, 4'hF);
            chk("b2b_w1_sel", b_sel, ch(k / 2));
            tick();
        end
        chk("b2b_w1_done", b_done, 1'b1);
        chk("b2b_gap_en", b_en, 1'b0);
        chk("b2b_gap_ready", b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b0;
        chk("b2b_w2_en", b_en, 1'b1);
        chk("b2b_w2_d", b_d, 4'h3);
        chk("b2b_w2_sel", b_sel, ch(0));
        chk("b2b_w2_done_clr", b_done, 1'b0);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("b2b_w2_en_run", b_en, 1'b1);
        end
        tick();
        chk("b2b_w2_done", b_done, 1'b1);
        chk("b2b_w2_en_fall", b_en, 1'b0);
        tick();
        chk("b2b_no_dup_busy", b_busy, 1'b0);
        chk("b2b_no_dup_en", b_en, 1'b0);
        chk("b2b_d_final", b_d, 4'h3);

        // DIV=1 on C: select changes every clock
        c_in_data  = 4'b0001;
        c_in_valid = 1'b1;
        tick();
        c_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("div1_en", c_en, 1'b1);
            chk("div1_sel", c_sel, ch(k));
            chk("div1_mux_out", bit_of(c_d, c_sel), bit_of(4'b0001, ch(k)));
            tick();
        end
        chk("div1_en_fall", c_en, 1'b0);
        chk("div1_done", c_done, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
